// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-level AXI stream arbiter.
package axis_packet_arbiter_pkg;

   typedef enum logic {IDLE, PASS} state_t;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr == n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first set request bit at or after ptr, wrapping.
module rr_priority_select
   import axis_packet_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any_req,
   output logic [IDX_W-1:0] sel
);

   localparam int unsigned NU = N;

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NU; i++) begin
         idx = IDX_W'((32'(ptr) + i) % NU);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging N_INPUTS AXI streams into one.
// Optional grant/packet-count outputs under AXIS_PACKET_ARBITER_GRANT_OUT_EN.
module axis_packet_arbiter
   import axis_packet_arbiter_pkg::*;
#(
   parameter  int N_INPUTS       = 2,
   parameter  int AXIS_BYTES     = 1,
   parameter  int AXIS_USER_BITS = 1,
   localparam int IDX_W          = idx_width(N_INPUTS)
) (
   input  logic                                clk,
   input  logic                                aresetn,
   input  logic [N_INPUTS-1:0]                 axis_i_tvalid,
   output logic [N_INPUTS-1:0]                 axis_i_tready,
   input  logic [N_INPUTS-1:0]                 axis_i_tlast,
   input  logic [N_INPUTS*AXIS_BYTES*8-1:0]    axis_i_tdata,
   input  logic [N_INPUTS*AXIS_BYTES-1:0]      axis_i_tkeep,
   input  logic [N_INPUTS*AXIS_USER_BITS-1:0]  axis_i_tuser,
   output logic                                axis_o_tvalid,
   input  logic                                axis_o_tready,
   output logic                                axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0]             axis_o_tdata,
   output logic [AXIS_BYTES-1:0]               axis_o_tkeep,
   output logic [AXIS_USER_BITS-1:0]           axis_o_tuser
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
   ,
   output logic [IDX_W-1:0]                    grant_idx,
   output logic                                grant_active,
   output logic [31:0]                         pkt_count
`endif
);

   localparam int DW = AXIS_BYTES * 8;
   localparam int KW = AXIS_BYTES;
   localparam int UW = AXIS_USER_BITS;

   state_t           state;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] rr_ptr;
   logic             any_req;
   logic [IDX_W-1:0] sel;
   logic             in_pass;
   logic             xfer;

   rr_priority_select #(
      .N     (N_INPUTS),
      .IDX_W (IDX_W)
   ) u_select (
      .req     (axis_i_tvalid),
      .ptr     (rr_ptr),
      .any_req (any_req),
      .sel     (sel)
   );

   assign in_pass = (state == PASS);

   // Zero-latency pass-through of the granted source; everything idles outside PASS.
   always_comb begin
      axis_o_tvalid = 1'b0;
      axis_o_tlast  = 1'b0;
      axis_o_tdata  = '0;
      axis_o_tkeep  = '0;
      axis_o_tuser  = '0;
      axis_i_tready = '0;
      for (int unsigned k = 0; k < N_INPUTS; k++) begin
         if (in_pass && grant == IDX_W'(k)) begin
            axis_o_tvalid    = axis_i_tvalid[k];
            axis_o_tlast     = axis_i_tlast[k];
            axis_o_tdata     = axis_i_tdata[k*DW +: DW];
            axis_o_tkeep     = axis_i_tkeep[k*KW +: KW];
            axis_o_tuser     = axis_i_tuser[k*UW +: UW];
            axis_i_tready[k] = axis_o_tready;
         end
      end
   end

   assign xfer = axis_o_tvalid && axis_o_tready;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
         pkt_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= sel;
                  state <= PASS;
               end
            end
            PASS: begin
               // Grant held until the tlast handshake; rotation starts after the winner.
               if (xfer && axis_o_tlast) begin
                  rr_ptr <= IDX_W'(rr_next(32'(grant), N_INPUTS));
                  state  <= IDLE;
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
                  pkt_count <= pkt_count + 32'd1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
   assign grant_idx    = grant;
   assign grant_active = in_pass;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter with three 1-byte sources.
module tb_axis_packet_arbiter;

   localparam int N = 3;

   logic           clk = 1'b0;
   logic           aresetn = 1'b0;
   logic [N-1:0]   i_tvalid;
   logic [N-1:0]   i_tready;
   logic [N-1:0]   i_tlast;
   logic [N*8-1:0] i_tdata;
   logic [N-1:0]   i_tkeep;
   logic [N-1:0]   i_tuser;
   logic           o_tvalid;
   logic           o_tready;
   logic           o_tlast;
   logic [7:0]     o_tdata;
   logic           o_tkeep;
   logic           o_tuser;
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
   logic [1:0]     grant_idx;
   logic           grant_active;
   logic [31:0]    pkt_count;
   logic [31:0]    cnt_before;
`endif

   always #5 clk = ~clk;

   axis_packet_arbiter #(
      .N_INPUTS       (N),
      .AXIS_BYTES     (1),
      .AXIS_USER_BITS (1)
   ) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .axis_i_tvalid (i_tvalid),
      .axis_i_tready (i_tready),
      .axis_i_tlast  (i_tlast),
      .axis_i_tdata  (i_tdata),
      .axis_i_tkeep  (i_tkeep),
      .axis_i_tuser  (i_tuser),
      .axis_o_tvalid (o_tvalid),
      .axis_o_tready (o_tready),
      .axis_o_tlast  (o_tlast),
      .axis_o_tdata  (o_tdata),
      .axis_o_tkeep  (o_tkeep),
      .axis_o_tuser  (o_tuser)
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
      ,
      .grant_idx     (grant_idx),
      .grant_active  (grant_active),
      .pkt_count     (pkt_count)
`endif
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } word_t;

   typedef struct {
      int         src;
      logic [7:0] data;
      logic       last;
      int         pre;
   } exp_t;

   word_t srcq[N][$];
   exp_t  expq[$];
   int    n_pass = 0;
   int    n_total = 0;
   int    n_xfer = 0;
   int    idle_run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, want);
   endtask

   // keep = data[0], user = data[1] so both sideband fields vary per word
   task automatic pkt(input int src, input logic [7:0] base, input int len,
                      input int gap_at, input int gap);
      word_t w;
      exp_t  e;
      for (int i = 0; i < len; i++) begin
         w.data = base + 8'(i);
         w.last = (i == len - 1);
         w.gap  = (i == gap_at) ? gap : 0;
         srcq[src].push_back(w);
         e.src  = src;
         e.data = w.data;
         e.last = w.last;
         e.pre  = (i == 0) ? 1 : w.gap;
         expq.push_back(e);
      end
   endtask

   task automatic wait_empty(input int budget);
      int c = 0;
      while (expq.size() != 0 && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      if (expq.size() != 0) begin
         n_total++;
         $display("FAIL wait_empty: %0d words still pending, expected 0", expq.size());
         expq.delete();
      end
   endtask

   task automatic wait_xfer(input int target, input int budget);
      int c = 0;
      while (n_xfer < target && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      if (n_xfer < target) begin
         n_total++;
         $display("FAIL wait_xfer: got %0d transfers, expected %0d", n_xfer, target);
      end
   endtask

   // Source drivers: hold head word until accepted; gap inserts tvalid=0 cycles.
   initial begin
      logic [N-1:0] acc;
      i_tvalid = '0;
      i_tlast  = '0;
      i_tdata  = '0;
      i_tkeep  = '0;
      i_tuser  = '0;
      forever begin
         @(negedge clk);
         acc = i_tvalid & i_tready;
         @(posedge clk); #2;
         for (int k = 0; k < N; k++) begin
            if (acc[k] && srcq[k].size() != 0) void'(srcq[k].pop_front());
            if (srcq[k].size() != 0 && srcq[k][0].gap > 0) begin
               srcq[k][0].gap--;
               i_tvalid[k] = 1'b0;
            end else if (srcq[k].size() != 0) begin
               i_tvalid[k]       = 1'b1;
               i_tlast[k]        = srcq[k][0].last;
               i_tdata[k*8 +: 8] = srcq[k][0].data;
               i_tkeep[k]        = srcq[k][0].data[0];
               i_tuser[k]        = srcq[k][0].data[1];
            end else begin
               i_tvalid[k] = 1'b0;
               i_tlast[k]  = 1'b0;
            end
         end
      end
   end

   // Monitor: compares every presented/accepted output word against the queue head.
   initial begin
      logic [N-1:0] allowed;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            idle_run = 0;
         end else begin
            allowed = '0;
            if (expq.size() != 0 && o_tready) allowed[expq[0].src] = 1'b1;
            chk("ready_mask", 32'(i_tready & ~allowed), 32'd0);
            if (o_tvalid) begin
               if (expq.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_word: got data %0h, expected no word", o_tdata);
               end else begin
                  chk("tdata", 32'(o_tdata), 32'(expq[0].data));
                  chk("tlast", 32'(o_tlast), 32'(expq[0].last));
                  chk("tkeep", 32'(o_tkeep), 32'(expq[0].data[0]));
                  chk("tuser", 32'(o_tuser), 32'(expq[0].data[1]));
                  if (o_tready) begin
                     chk("ready_onehot", 32'(i_tready), 32'(1) << expq[0].src);
                     chk("idle_cycles", 32'(idle_run), 32'(expq[0].pre));
                     void'(expq.pop_front());
                     n_xfer++;
                     idle_run = 0;
                  end
               end
            end else if (expq.size() != 0) begin
               idle_run++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      n_total++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      o_tready = 1'b1;
      aresetn  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(o_tvalid), 32'd0);
      chk("rst_tready", 32'(i_tready), 32'd0);
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
      chk("rst_pkt_count", pkt_count, 32'd0);
      chk("rst_grant_active", 32'(grant_active), 32'd0);
`endif
      aresetn = 1'b1;
      @(posedge clk); #1;

      // Lone src1, 4-word packet
      pkt(1, 8'h10, 4, -1, 0);
      wait_empty(50);

      // rr_ptr=2, only src0 requests: wrap search must pick src0
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
      cnt_before = pkt_count;
`endif
      pkt(0, 8'h20, 2, -1, 0);
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
      @(posedge clk); #1;
      chk("wrap_grant_active", 32'(grant_active), 32'd1);
      chk("wrap_grant_idx", 32'(grant_idx), 32'd0);
`endif
      wait_empty(50);
`ifdef AXIS_PACKET_ARBITER_GRANT_OUT_EN
      chk("pkt_count_inc", pkt_count, cnt_before + 32'd1);
`endif

      // Single-word src1 packet leaves rr_ptr=2 before the reset test
      pkt(1, 8'h30, 1, -1, 0);
      wait_empty(50);

      // Reset mid-packet, then src1/src2 together: rr_ptr must be back at 0
      base = n_xfer;
      pkt(0, 8'h40, 6, -1, 0);
      wait_xfer(base + 2, 50);
      aresetn = 1'b0;
      for (int k = 0; k < N; k++) srcq[k].delete();
      expq.delete();
      #2;
      chk("rst_mid_tvalid", 32'(o_tvalid), 32'd0);
      chk("rst_mid_tready", 32'(i_tready), 32'd0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      pkt(1, 8'h58, 2, -1, 0);
      pkt(2, 8'h50, 2, -1, 0);
      wait_empty(50);

      // All three requesting: grants 0,1,2,0 with one bubble between packets
      pkt(0, 8'h60, 2, -1, 0);
      pkt(1, 8'h62, 2, -1, 0);
      pkt(2, 8'h64, 2, -1, 0);
      pkt(0, 8'h66, 2, -1, 0);
      wait_empty(100);

      // src0 pauses 3 cycles mid-packet while src2 waits; then output backpressure
      base = n_xfer;
      pkt(0, 8'h70, 3, 1, 3);
      wait_xfer(base + 1, 50);
      pkt(2, 8'h80, 4, -1, 0);
      wait_xfer(base + 4, 50);
      o_tready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_tready", 32'(i_tready), 32'd0);
         chk("stall_tvalid", 32'(o_tvalid), 32'd1);
         chk("stall_tdata", 32'(o_tdata), 32'h81);
      end
      o_tready = 1'b1;
      wait_empty(50);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
